// File: rtl/rojobot_defs.sv
// Shared definitions for the rojobot2 motion model.
package rojobot_defs;

    localparam int unsigned HEADING_W    = 3;
    localparam int unsigned SPEED_W      = 3;
    localparam int unsigned MOT_W        = 3;
    localparam int unsigned TICK_MAX_SIM = 5;
    localparam int unsigned TICK_MAX_HW  = 19_999_999;

    typedef enum logic [MOT_W-1:0] {
        MOT_STOP   = 3'd0,
        MOT_FWD    = 3'd1,
        MOT_REV    = 3'd2,
        MOT_SPIN_R = 3'd3,
        MOT_SPIN_L = 3'd4,
        MOT_PIVOT  = 3'd5
    } mot_state_e;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_FWD  = 2'd1,
        CMD_REV  = 2'd2
    } wheel_cmd_e;

    // Both or neither button pressed means no command.
    function automatic wheel_cmd_e decode_cmd(input logic fwd, input logic rev);
        case ({fwd, rev})
            2'b10:   return CMD_FWD;
            2'b01:   return CMD_REV;
            default: return CMD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rojobot_tick.sv
// Update-rate divider: one-clock tick every TICK_MAX+1 clocks.
module rojobot_tick
    import rojobot_defs::*;
#(
    parameter int unsigned SIMULATE = 0
)(
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int unsigned TICK_MAX = (SIMULATE != 0) ? TICK_MAX_SIM : TICK_MAX_HW;
    localparam int unsigned CNT_W    = $clog2(TICK_MAX + 1);

    logic [CNT_W-1:0] cnt;

    // Free-running count; tick pulses as the counter wraps from TICK_MAX.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CNT_W'(TICK_MAX)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/rojobot_wheel.sv
// One wheel: speed ramp with brake-before-reverse and position integration.
module rojobot_wheel
    import rojobot_defs::*;
#(
    parameter int unsigned POS_WIDTH = 8,
    parameter int unsigned MAX_SPEED = 3,
    parameter int unsigned WRAP      = 1
)(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tick,
    input  logic                 fwd,
    input  logic                 rev,
    output logic [POS_WIDTH-1:0] pos,
    output logic [SPEED_W-1:0]   speed,
    output logic                 dir
);

    localparam int unsigned PW1 = POS_WIDTH + 1;

    wheel_cmd_e           cmd;
    logic                 cmd_rev;
    logic [PW1-1:0]       sum;
    logic [POS_WIDTH-1:0] pos_nxt;
    logic [SPEED_W-1:0]   speed_nxt;
    logic                 dir_nxt;

    // Next state from pre-tick speed/dir; sum carries one extra bit to spot over/underflow.
    always_comb begin
        cmd       = decode_cmd(fwd, rev);
        cmd_rev   = (cmd == CMD_REV);
        sum       = dir ? ({1'b0, pos} - PW1'(speed)) : ({1'b0, pos} + PW1'(speed));
        pos_nxt   = sum[POS_WIDTH-1:0];
        speed_nxt = speed;
        dir_nxt   = dir;

        if (WRAP == 0 && sum[POS_WIDTH]) begin
            pos_nxt = dir ? '0 : '1;
        end

        if (cmd == CMD_NONE) begin
            speed_nxt = '0;
        end else if (cmd_rev == dir || speed == '0) begin
            dir_nxt   = cmd_rev;
            speed_nxt = (speed >= SPEED_W'(MAX_SPEED)) ? SPEED_W'(MAX_SPEED) : speed + SPEED_W'(1);
        end else begin
            speed_nxt = '0;
        end
    end

    // Wheel registers advance only on tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos   <= '0;
            speed <= '0;
            dir   <= 1'b0;
        end else if (tick) begin
            pos   <= pos_nxt;
            speed <= speed_nxt;
            dir   <= dir_nxt;
        end
    end

endmodule

// File: rtl/rojobot2.sv
// Two-wheel robot motion model: divider, two wheels, heading and motion decode.
module rojobot2
    import rojobot_defs::*;
#(
    parameter int unsigned SIMULATE  = 0,
    parameter int unsigned POS_WIDTH = 8,
    parameter int unsigned MAX_SPEED = 3,
    parameter int unsigned WRAP      = 1
)(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 left_fwd,
    input  logic                 left_rev,
    input  logic                 right_fwd,
    input  logic                 right_rev,
    output logic [POS_WIDTH-1:0] left_pos,
    output logic [POS_WIDTH-1:0] right_pos,
    output logic [SPEED_W-1:0]   left_speed,
    output logic [SPEED_W-1:0]   right_speed,
    output logic                 left_dir,
    output logic                 right_dir,
    output logic [HEADING_W-1:0] heading,
    output logic [MOT_W-1:0]     mot_state,
    output logic                 tick
);

    mot_state_e mot;
    logic       left_mv;
    logic       right_mv;

    rojobot_tick #(.SIMULATE(SIMULATE)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    rojobot_wheel #(.POS_WIDTH(POS_WIDTH), .MAX_SPEED(MAX_SPEED), .WRAP(WRAP)) u_left (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .fwd     (left_fwd),
        .rev     (left_rev),
        .pos     (left_pos),
        .speed   (left_speed),
        .dir     (left_dir)
    );

    rojobot_wheel #(.POS_WIDTH(POS_WIDTH), .MAX_SPEED(MAX_SPEED), .WRAP(WRAP)) u_right (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .fwd     (right_fwd),
        .rev     (right_rev),
        .pos     (right_pos),
        .speed   (right_speed),
        .dir     (right_dir)
    );

    assign left_mv  = (left_speed != '0);
    assign right_mv = (right_speed != '0);

    // Heading turns one octant per tick while both wheels spin in opposite directions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            heading <= '0;
        end else if (tick && left_mv && right_mv) begin
            if (!left_dir && right_dir) begin
                heading <= heading + HEADING_W'(1);
            end else if (left_dir && !right_dir) begin
                heading <= heading - HEADING_W'(1);
            end
        end
    end

    // Motion state decoded straight from the wheel registers.
    always_comb begin
        mot = MOT_STOP;
        if (left_mv && right_mv) begin
            case ({left_dir, right_dir})
                2'b00:   mot = MOT_FWD;
                2'b11:   mot = MOT_REV;
                2'b01:   mot = MOT_SPIN_R;
                default: mot = MOT_SPIN_L;
            endcase
        end else if (left_mv || right_mv) begin
            mot = MOT_PIVOT;
        end
        mot_state = mot;
    end

endmodule
